xor_acc_sched: RTL and testbench

//   Round-robin scheduler that shares one W-bit XOR-accumulate register between NREQ requesters.

---
 rtl/xor_acc_sched.sv | 151 +++++++++++++++
 tb/tb_xor_acc_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_acc_sched.sv
// xor_acc_sched
//   Round-robin front end for one shared W-bit accumulate register.
//   Each granted request either loads its operand (mode=1) or XORs it into the
//   accumulator (mode=0). An op completes one cycle after its handshake.
//   Peak throughput is therefore one op every two cycles.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, one-hot or zero (forced low during rst)
//   req_data   operands, requester i at [i*W +: W]
//   req_mode   per-requester op: 1=load, 0=xor-accumulate
//   clr        synchronous accumulator clear (wins over a completing op)
//   acc_out    accumulator value
//   acc_owner  requester index of the last completed op
//   busy       high while an op is executing
//   done       one-cycle pulse when acc_out/acc_owner have just been updated
//
// state | meaning
// IDLE  | arbitrate; the winner is handshaken combinationally and captured
// EXEC  | apply the captured op to the accumulator, pulse done next cycle

module xor_acc_sched #(
    parameter int  NREQ = 4,
    parameter int  W    = 8,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_mode,
    input  logic              clr,
    output logic [W-1:0]      acc_out,
    output logic [IW-1:0]     acc_owner,
    output logic              busy,
    output logic              done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  data_q, data_d;
    logic          mode_q, mode_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          done_q, done_d;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic [W-1:0]  sel_data;
    logic [NREQ-1:0] grant_vec;

    // Search starts just after the last winner, so the last winner has the
    // lowest priority; the modulo handles the wrap from NREQ-1 back to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_data = req_data[i*W +: W];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (state_q == ST_IDLE && found && !rst) begin
            grant_vec[win] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        owner_d  = owner_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    data_d   = sel_data;
                    mode_d   = req_mode[win];
                    idx_d    = win;
                    rr_ptr_d = win;
                    state_d  = ST_EXEC;
                end
            end
            default: begin
                acc_d   = mode_q ? data_q : (acc_q ^ data_q);
                owner_d = idx_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        // clr overrides the accumulator result only; the op still completes.
        if (clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= IW'(NREQ - 1);
            data_q   <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            owner_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            owner_q  <= owner_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = grant_vec;
    assign acc_out   = acc_q;
    assign acc_owner = owner_q;
    assign busy      = (state_q == ST_EXEC);
    assign done      = done_q;

endmodule

// File: tb/tb_xor_acc_sched.sv
// Bench for xor_acc_sched: directed scenarios followed by randomized traffic.
// A reference model (per-cycle grant/accumulate rules) pushes expected op
// results into a queue; a separate monitor pops them whenever done is seen.

module tb_xor_acc_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_mode = '0;
    logic              clr = 1'b0;
    logic [W-1:0]      acc_out;
    logic [IW-1:0]     acc_owner;
    logic              busy;
    logic              done;

    logic [W-1:0] rd [NREQ];

    int total = 0;
    int bad   = 0;

    logic [W+IW-1:0] exp_q[$];

    // reference model state
    bit        m_exec;
    int        m_ptr;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_data;
    bit        m_mode;
    int        m_idx;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = rd[i];
    end

    xor_acc_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mode(req_mode),
        .clr(clr), .acc_out(acc_out), .acc_owner(acc_owner),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_exec = 0;
        m_ptr  = NREQ - 1;
        m_acc  = '0;
        m_data = '0;
        m_mode = 0;
        m_idx  = 0;
    endtask

    // Reference model: checks per-cycle outputs, then advances one clock.
    initial begin
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    nacc;
        int              w;
        m_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", 32'(req_ready), 32'd0);
                chk("rst_busy",  32'(busy),      32'd0);
                chk("rst_done",  32'(done),      32'd0);
                chk("rst_acc",   32'(acc_out),   32'd0);
                chk("rst_owner", 32'(acc_owner), 32'd0);
                m_reset();
                exp_q.delete();
                continue;
            end
            w = m_exec ? -1 : pick(req_valid, m_ptr);
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy",  32'(busy),      32'(m_exec));
            chk("acc",   32'(acc_out),   32'(m_acc));
            if (m_exec) begin
                nacc = clr ? '0 : (m_mode ? m_data : (m_acc ^ m_data));
                chk("done_missing", 32'(exp_q.size()), 32'd0);
                exp_q.push_back({nacc, IW'(m_idx)});
                m_acc  = nacc;
                m_exec = 0;
            end else begin
                if (clr) m_acc = '0;
                if (w >= 0) begin
                    m_data = rd[w];
                    m_mode = req_mode[w];
                    m_idx  = w;
                    m_ptr  = w;
                    m_exec = 1;
                end
            end
        end
    end

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        logic [W+IW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected actual=1 required=0 t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_acc",   32'(acc_out),   32'(e[W+IW-1:IW]));
                    chk("done_owner", 32'(acc_owner), 32'(e[IW-1:0]));
                end
            end
        end
    end

    task automatic wait_ready(input int i);
        bit ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1;
        end
        chk("wait_ready", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        chk("wait_done", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] grants[$];
        for (int i = 0; i < NREQ; i++) rd[i] = '0;

        // reset held with all requesters valid; then round robin 0,1,2,3
        rst = 1'b1;
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        rd[0] = 8'h01; rd[1] = 8'h02; rd[2] = 8'h04; rd[3] = 8'h08;
        req_mode = 4'b0000;
        @(negedge clk);
        chk("t1_ready_after_release", 32'(req_ready), 32'h1);
        repeat (4) wait_done();
        chk("t3_acc_after_four", 32'(acc_out), 32'h0F);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // load A5 then xor 0F
        #1;
        req_valid = 4'b0001; req_mode = 4'b0001; rd[0] = 8'hA5;
        wait_ready(0);
        @(posedge clk); #1;
        req_mode = 4'b0000; rd[0] = 8'h0F;
        wait_done();
        chk("t2_acc_load", 32'(acc_out), 32'hA5);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done();
        chk("t2_acc_xor", 32'(acc_out), 32'hAA);
        chk("t2_owner", 32'(acc_owner), 32'd0);

        // clr coinciding with the EXEC edge of a load
        @(posedge clk); #1;
        req_valid = 4'b0100; req_mode = 4'b0100; rd[2] = 8'hFF;
        wait_ready(2);
        @(posedge clk); #1;
        clr = 1'b1; req_valid = '0;
        wait_done();
        chk("t4_acc_clr", 32'(acc_out), 32'h00);
        chk("t4_owner", 32'(acc_owner), 32'd2);
        @(posedge clk); #1;
        clr = 1'b0;

        // reset during EXEC of req1
        req_valid = 4'b0010; req_mode = 4'b0010; rd[1] = 8'h33;
        wait_ready(1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'b1010; req_mode = 4'b0000; rd[3] = 8'h5A;
        @(negedge clk);
        chk("t5_ready_req1_first", 32'(req_ready), 32'h2);
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_acc_zero", 32'(acc_out), 32'd0);

        // after req1, alternate 3,1,3
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (req_ready != 0) grants.push_back(req_ready);
        end
        chk("t6_grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 3) begin
            chk("t6_grant0", 32'(grants[0]), 32'h8);
            chk("t6_grant1", 32'(grants[1]), 32'h2);
            chk("t6_grant2", 32'(grants[2]), 32'h8);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // randomized traffic, occasional clr and reset pulses
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst = 1'b1;
            clr = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || (!req_valid[i] && $urandom_range(0, 2) == 0)) begin
                    req_valid[i] = g[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                    rd[i]        = W'($urandom);
                    req_mode[i]  = ($urandom_range(0, 3) == 0);
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end

        @(posedge clk); #1;
        rst = 1'b0; clr = 1'b0; req_valid = '0;
        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
